// File: rtl/cfg_pkg.sv
// Shared register map, control codes, state encoding and step decode
// for the cfg Wishbone loader.
package cfg_pkg;

    localparam logic [31:0] ADDR_OFS   = 32'h0000_0000;
    localparam logic [31:0] CTRL_OFS   = 32'h0000_0004;
    localparam logic [31:0] DATA0_OFS  = 32'h0000_0008;
    localparam logic [31:0] CTRL_STORE = 32'h0000_0001;
    localparam logic [31:0] CTRL_LOAD  = 32'h0000_0002;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_GAP,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } xfer_t;

    function automatic logic [2:0] clamp_n(input logic [2:0] n);
        if (n == 3'd0) return 3'd1;
        if (n > 3'd4) return 3'd4;
        return n;
    endfunction

    // Store: DATA_0..n-1, ADDR, CTRL. Load: ADDR, CTRL, DATA_0..n-1.
    function automatic xfer_t step_desc(
        input logic [31:0]  base,
        input logic         op,
        input logic [2:0]   step,
        input logic [2:0]   n,
        input logic [31:0]  addr,
        input logic [127:0] wdata
    );
        xfer_t      x;
        logic [2:0] k;
        x = '0;
        k = step - 3'd2;
        if (!op) begin
            x.we = 1'b1;
            if (step < n) begin
                x.adr = base + DATA0_OFS + {27'd0, step, 2'b00};
                x.dat = wdata[{step[1:0], 5'd0} +: 32];
            end else if (step == n) begin
                x.adr = base + ADDR_OFS;
                x.dat = addr;
            end else begin
                x.adr = base + CTRL_OFS;
                x.dat = CTRL_STORE;
            end
        end else if (step == 3'd0) begin
            x.we  = 1'b1;
            x.adr = base + ADDR_OFS;
            x.dat = addr;
        end else if (step == 3'd1) begin
            x.we  = 1'b1;
            x.adr = base + CTRL_OFS;
            x.dat = CTRL_LOAD;
        end else begin
            x.adr = base + DATA0_OFS + {27'd0, k, 2'b00};
        end
        return x;
    endfunction

endpackage

// File: rtl/cfg_wb_xfer.sv
// Single Wishbone transfer engine: strobe until ack or timeout, then a
// fixed idle gap during which stray acks are ignored.
module cfg_wb_xfer
    import cfg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_BW     = 5,
    parameter int GAP_CYCLES     = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    output logic        ack_o,
    output logic        done_o,
    output logic        err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i
);

    localparam int GBW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TIMEOUT_BW-1:0] TO_LAST = TIMEOUT_BW'(TIMEOUT_CYCLES - 1);
    localparam logic [GBW-1:0] GAP_LAST = GBW'(GAP_CYCLES - 1);

    state_e                st_q;
    logic                  stb_q;
    logic                  we_q;
    logic [31:0]           adr_q;
    logic [31:0]           dat_q;
    logic [TIMEOUT_BW-1:0] to_q;
    logic [GBW-1:0]        gap_q;
    logic                  start;

    assign done_o = (st_q == ST_GAP) && (gap_q == '0);
    assign ack_o  = (st_q == ST_XFER) && wbm_ack_i;
    assign err_o  = (st_q == ST_XFER) && !wbm_ack_i && (to_q == TO_LAST);
    // A new transfer may start on the last gap cycle, keeping 3+GAP per word.
    assign start  = req_i && ((st_q == ST_IDLE) || done_o);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            st_q  <= ST_IDLE;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            to_q  <= '0;
            gap_q <= '0;
        end else if (start) begin
            st_q  <= ST_XFER;
            stb_q <= 1'b1;
            we_q  <= we_i;
            adr_q <= adr_i;
            dat_q <= dat_i;
            to_q  <= '0;
        end else begin
            case (st_q)
                ST_XFER: begin
                    if (wbm_ack_i) begin
                        stb_q <= 1'b0;
                        st_q  <= ST_GAP;
                        gap_q <= GAP_LAST;
                    end else if (to_q == TO_LAST) begin
                        stb_q <= 1'b0;
                        st_q  <= ST_IDLE;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_q != '0) gap_q <= gap_q - 1'b1;
                    else st_q <= ST_IDLE;
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end

    assign wbm_cyc_o = stb_q;
    assign wbm_stb_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = {4{stb_q}};
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule

// File: rtl/cfg_wb_loader.sv
// Sequences cfg register stores/loads over Wishbone. Optional verify pass
// after each store when CFG_WB_LOADER_READBACK_EN is defined.
module cfg_wb_loader
    import cfg_pkg::*;
#(
    parameter logic [31:0] WISHBONE_BASE_ADDR = 32'h3000_0000,
    parameter int          GAP_CYCLES         = 2,
    parameter int          TIMEOUT_CYCLES     = 16,
    parameter int          TIMEOUT_BW         = 5
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic         cmd_op_i,
    input  logic [31:0]  cmd_addr_i,
    input  logic [2:0]   cmd_nwords_i,
    input  logic [127:0] cmd_wdata_i,
    output logic         rsp_valid_o,
    output logic         rsp_err_o,
    output logic [127:0] rsp_rdata_o,
    output logic         wbm_cyc_o,
    output logic         wbm_stb_o,
    output logic         wbm_we_o,
    output logic [3:0]   wbm_sel_o,
    output logic [31:0]  wbm_adr_o,
    output logic [31:0]  wbm_dat_o,
    input  logic [31:0]  wbm_dat_i,
    input  logic         wbm_ack_i
);

    state_e         st_q;
    logic           op_q;
    logic [2:0]     n_q;
    logic [2:0]     step_q;
    logic [31:0]    addr_q;
    logic [127:0]   wdata_q;
    logic [127:0]   rdata_q;
    logic           err_q;
    logic           rsp_q;
`ifdef CFG_WB_LOADER_READBACK_EN
    logic           rb_q;
`endif

    logic           op_c;
    logic [2:0]     step_c;
    logic [2:0]     n_c;
    logic [31:0]    addr_c;
    logic [127:0]   wdata_c;
    logic           seq_end;
    logic           x_req;
    logic           x_ack;
    logic           x_done;
    logic           x_err;
    logic [1:0]     widx;
    xfer_t          cur;

    // step_q already points at the next step when the gap ends.
    always_comb begin
        op_c    = op_q;
        step_c  = step_q;
        n_c     = n_q;
        addr_c  = addr_q;
        wdata_c = wdata_q;
        if (st_q == ST_IDLE) begin
            op_c    = cmd_op_i;
            step_c  = 3'd0;
            n_c     = clamp_n(cmd_nwords_i);
            addr_c  = cmd_addr_i;
            wdata_c = cmd_wdata_i;
        end
`ifdef CFG_WB_LOADER_READBACK_EN
        else if (!op_q && step_q == n_q + 3'd2) begin
            op_c   = 1'b1;
            step_c = 3'd0;
        end
`endif
        seq_end = (step_c == n_c + 3'd2);
        cur     = step_desc(WISHBONE_BASE_ADDR, op_c, step_c, n_c,
                            addr_c, wdata_c);
        x_req   = ((st_q == ST_IDLE) && cmd_valid_i) ||
                  ((st_q == ST_XFER) && x_done && !seq_end);
    end

    assign widx = step_q[1:0] - 2'd2;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            st_q    <= ST_IDLE;
            op_q    <= 1'b0;
            n_q     <= '0;
            step_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            rsp_q   <= 1'b0;
`ifdef CFG_WB_LOADER_READBACK_EN
            rb_q    <= 1'b0;
`endif
        end else begin
            case (st_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        st_q    <= ST_XFER;
                        op_q    <= cmd_op_i;
                        n_q     <= clamp_n(cmd_nwords_i);
                        addr_q  <= cmd_addr_i;
                        wdata_q <= cmd_wdata_i;
                        step_q  <= 3'd0;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
`ifdef CFG_WB_LOADER_READBACK_EN
                        rb_q    <= 1'b0;
`endif
                    end
                end
                ST_XFER: begin
                    if (x_err) begin
                        st_q    <= ST_RESP;
                        rsp_q   <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else if (x_ack) begin
                        step_q <= step_q + 3'd1;
                        if (op_q && step_q >= 3'd2) begin
                            rdata_q[{widx, 5'd0} +: 32] <= wbm_dat_i;
`ifdef CFG_WB_LOADER_READBACK_EN
                            if (rb_q && wbm_dat_i != wdata_q[{widx, 5'd0} +: 32])
                                err_q <= 1'b1;
`endif
                        end
                    end else if (x_done) begin
                        if (seq_end) begin
                            st_q  <= ST_RESP;
                            rsp_q <= 1'b1;
                        end else begin
                            op_q   <= op_c;
                            step_q <= step_c;
`ifdef CFG_WB_LOADER_READBACK_EN
                            rb_q   <= rb_q | (op_c != op_q);
`endif
                        end
                    end
                end
                default: begin
                    rsp_q <= 1'b0;
                    st_q  <= ST_IDLE;
                end
            endcase
        end
    end

    cfg_wb_xfer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_BW     (TIMEOUT_BW),
        .GAP_CYCLES     (GAP_CYCLES)
    ) u_xfer (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .req_i     (x_req),
        .we_i      (cur.we),
        .adr_i     (cur.adr),
        .dat_i     (cur.dat),
        .ack_o     (x_ack),
        .done_o    (x_done),
        .err_o     (x_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i)
    );

    assign cmd_ready_o = (st_q == ST_IDLE);
    assign rsp_valid_o = rsp_q;
    assign rsp_err_o   = err_q;
    assign rsp_rdata_o = rdata_q;

endmodule

// File: tb/tb_cfg_wb_loader.sv
// Randomized bench for cfg_wb_loader against a transaction-level model
// and a simple cfg slave with adjustable ack length.
module tb_cfg_wb_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_op = 1'b0;
    logic [31:0]  cmd_addr = '0;
    logic [2:0]   cmd_nwords = '0;
    logic [127:0] cmd_wdata = '0;
    logic         rsp_valid;
    logic         rsp_err;
    logic [127:0] rsp_rdata;
    logic         wbm_cyc;
    logic         wbm_stb;
    logic         wbm_we;
    logic [3:0]   wbm_sel;
    logic [31:0]  wbm_adr;
    logic [31:0]  wbm_dat;
    logic [31:0]  wbm_dat_i = '0;
    logic         wbm_ack = 1'b0;

    always #5 clk = ~clk;

    cfg_wb_loader dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_addr_i   (cmd_addr),
        .cmd_nwords_i (cmd_nwords),
        .cmd_wdata_i  (cmd_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_err_o    (rsp_err),
        .rsp_rdata_o  (rsp_rdata),
        .wbm_cyc_o    (wbm_cyc),
        .wbm_stb_o    (wbm_stb),
        .wbm_we_o     (wbm_we),
        .wbm_sel_o    (wbm_sel),
        .wbm_adr_o    (wbm_adr),
        .wbm_dat_o    (wbm_dat),
        .wbm_dat_i    (wbm_dat_i),
        .wbm_ack_i    (wbm_ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave: ack appears 2 cycles into the strobe, held for ack_len cycles.
    logic [31:0] rd_mem [4];
    logic [31:0] wr_mem [4];
    int          ack_len = 1;
    bit          no_ack = 1'b0;
    bit          corrupt = 1'b0;
    bit          echo_wr = 1'b0;
    bit          proto_bad = 1'b0;
    int          scnt = 0;
    int          hold = 0;
    logic [64:0] log_q [$];
    logic [64:0] exp_q [$];

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE - 32'h8) >> 2) & 3;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbm_ack <= 1'b0;
            scnt    <= 0;
            hold    <= 0;
        end else begin
            if (wbm_cyc !== wbm_stb || wbm_sel !== (wbm_stb ? 4'hF : 4'h0))
                proto_bad <= 1'b1;
            if (hold > 0) begin
                hold <= hold - 1;
                if (hold == 1) wbm_ack <= 1'b0;
            end else if (wbm_stb && !no_ack) begin
                if (scnt == 1) begin
                    scnt    <= 0;
                    hold    <= ack_len;
                    wbm_ack <= 1'b1;
                    if (wbm_we) begin
                        log_q.push_back({1'b1, wbm_adr, wbm_dat});
                        if (wbm_adr >= BASE + 32'h8)
                            wr_mem[word_of(wbm_adr)] <= wbm_dat;
                    end else begin
                        log_q.push_back({1'b0, wbm_adr, 32'h0});
                        wbm_dat_i <= (echo_wr ? wr_mem[word_of(wbm_adr)]
                                              : rd_mem[word_of(wbm_adr)])
                                     ^ ((corrupt && word_of(wbm_adr) == 1)
                                        ? 32'h0000_0100 : 32'h0);
                    end
                end else begin
                    scnt <= scnt + 1;
                end
            end else begin
                scnt <= 0;
            end
        end
    end

    // Reference: the register-level sequence a command should produce.
    task automatic run_cmd(input string tag, input bit op, input logic [31:0] a,
                           input logic [2:0] nw, input logic [127:0] wd);
        int           ne;
        int           lat;
        int           hi;
        bit           got;
        logic [127:0] exp_rd;
        bit           exp_err;
        ne      = (nw == 0) ? 1 : ((nw > 4) ? 4 : int'(nw));
        exp_rd  = '0;
        exp_err = 1'b0;
        exp_q.delete();
        if (!op) begin
            for (int k = 0; k < ne; k++)
                exp_q.push_back({1'b1, BASE + 32'h8 + 32'(4 * k), wd[32 * k +: 32]});
            exp_q.push_back({1'b1, BASE, a});
            exp_q.push_back({1'b1, BASE + 32'h4, 32'h1});
`ifdef CFG_WB_LOADER_READBACK_EN
            exp_q.push_back({1'b1, BASE, a});
            exp_q.push_back({1'b1, BASE + 32'h4, 32'h2});
            for (int k = 0; k < ne; k++) begin
                exp_q.push_back({1'b0, BASE + 32'h8 + 32'(4 * k), 32'h0});
                exp_rd[32 * k +: 32] = wd[32 * k +: 32] ^
                    ((corrupt && k == 1) ? 32'h100 : 32'h0);
            end
            exp_err = corrupt && ne >= 2;
`endif
        end else begin
            exp_q.push_back({1'b1, BASE, a});
            exp_q.push_back({1'b1, BASE + 32'h4, 32'h2});
            for (int k = 0; k < ne; k++) begin
                exp_q.push_back({1'b0, BASE + 32'h8 + 32'(4 * k), 32'h0});
                exp_rd[32 * k +: 32] = rd_mem[k] ^
                    ((corrupt && k == 1) ? 32'h100 : 32'h0);
            end
        end
        if (no_ack) begin
            exp_q.delete();
            exp_rd  = '0;
            exp_err = 1'b1;
        end
        echo_wr = !op;
        log_q.delete();
        @(negedge clk);
        check({tag, ".ready"}, 128'(cmd_ready), 128'(1));
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_addr   = a;
        cmd_nwords = nw;
        cmd_wdata  = wd;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_wdata = '0;
        hi  = wbm_stb ? 1 : 0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 600) begin
            @(posedge clk);
            #1 lat++;
            if (wbm_stb) hi++;
            if (rsp_valid) got = 1'b1;
        end
        check({tag, ".rsp_seen"}, 128'(got), 128'(1));
        check({tag, ".latency"}, 128'(lat),
              128'(no_ack ? 16 : 5 * exp_q.size()));
        check({tag, ".stb_cycles"}, 128'(hi),
              128'(no_ack ? 16 : 3 * exp_q.size()));
        check({tag, ".ready_in_resp"}, 128'(cmd_ready), 128'(0));
        check({tag, ".err"}, 128'(rsp_err), 128'(exp_err));
        check({tag, ".rdata"}, rsp_rdata, exp_rd);
        check({tag, ".nxfers"}, 128'(log_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("%s.xfer%0d", tag, i), 128'(log_q[i]), 128'(exp_q[i]));
        @(posedge clk);
        #1;
        check({tag, ".pulse_len"}, 128'(rsp_valid), 128'(0));
        check({tag, ".ready_after"}, 128'(cmd_ready), 128'(1));
        check({tag, ".rdata_held"}, rsp_rdata, exp_rd);
    endtask

    initial begin
        int wait_cyc;
        for (int k = 0; k < 4; k++) begin
            rd_mem[k] = '0;
            wr_mem[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.stb", 128'(wbm_stb), 128'(0));
        check("reset.ready", 128'(cmd_ready), 128'(1));
        rst_n = 1'b1;
        #1;
        check("reset.rsp", {rsp_valid, rsp_err, wbm_cyc, wbm_we, wbm_sel},
              128'(0));
        check("reset.rdata", rsp_rdata, 128'(0));
        check("reset.adr", 128'({wbm_adr, wbm_dat}), 128'(0));

        run_cmd("conv1_store", 1'b0, 32'h030, 3'd4,
                128'h00AB_CDEF_3333_3333_2222_2222_1111_1111);
        rd_mem[0] = 32'hDEAD_BEEF;
        rd_mem[1] = 32'h1234_5678;
        run_cmd("fc_load", 1'b1, 32'h300, 3'd1, '0);
        ack_len = 3;
        run_cmd("echo_store", 1'b0, 32'h044, 3'd4,
                128'h4444_4444_3333_3333_2222_2222_1111_1111);
        ack_len = 1;
        run_cmd("store_n0", 1'b0, 32'h100, 3'd0, 128'hFFFF_0000_AAAA_5555);
        run_cmd("load_n7", 1'b1, 32'h200, 3'd7, '0);
        no_ack = 1'b1;
        run_cmd("timeout", 1'b0, 32'h010, 3'd2, 128'h55);
        no_ack = 1'b0;
`ifdef CFG_WB_LOADER_READBACK_EN
        corrupt = 1'b1;
        run_cmd("rb_corrupt", 1'b0, 32'h080, 3'd3,
                128'h0 | 96'hCCCC_0000_BBBB_0000_AAAA_0000);
        corrupt = 1'b0;
`endif

        for (int i = 0; i < 20; i++) begin
            ack_len = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) rd_mem[k] = $urandom;
            run_cmd($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                    $urandom, 3'($urandom_range(0, 7)),
                    {$urandom, $urandom, $urandom, $urandom});
        end
        ack_len = 1;

        // Reset while the second transfer is on the bus.
        log_q.delete();
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_op     = 1'b0;
        cmd_addr   = 32'h030;
        cmd_nwords = 3'd4;
        cmd_wdata  = 128'h1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_cyc = 0;
        while (!(log_q.size() == 1 && wbm_stb) && wait_cyc < 100) begin
            @(posedge clk);
            #1 wait_cyc++;
        end
        check("rst_mid.reached", 128'(wait_cyc < 100), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid.bus", 128'({wbm_stb, wbm_cyc, rsp_valid}), 128'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid.ready", 128'(cmd_ready), 128'(1));
        check("rst_mid.idle", 128'({wbm_stb, rsp_valid}), 128'(0));
        run_cmd("post_reset", 1'b1, 32'h300, 3'd2, '0);

        check("bus_protocol", 128'(proto_bad), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cfg_wb_loader.md
Name: cfg_wb_loader

Overview:
- Wishbone initiator that drives the cfg slave register file: ADDR at base+0x00, CTRL at +0x04, DATA_0..3 at +0x08..+0x14.
- Turns one high-level store or load command into the full cfg register sequence.
- Sits between a boot/host sequencer and the cfg slave; loads conv1/conv2/fc weights, biases and shifts without software.

Parameters:
- WISHBONE_BASE_ADDR, 32'h30000000, base address of the cfg register window.
- GAP_CYCLES, 2, idle cycles with stb low after every ack; covers the slave's 2-cycle delayed-ack echo.
- TIMEOUT_CYCLES, 16, maximum cycles stb stays high waiting for ack.
- TIMEOUT_BW, 5, width of the timeout counter.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; asynchronous, active-low
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  high only in IDLE
- cmd_op_i  in  1  0=store, 1=load
- cmd_addr_i  in  32  wakey address written to ADDR
- cmd_nwords_i  in  3  DATA words to transfer, 1..4
- cmd_wdata_i  in  128  store data; word k = bits [32k+31:32k]
- rsp_valid_o  out  1  one-cycle completion pulse
- rsp_err_o  out  1  timeout (or readback mismatch, see Optional Feature)
- rsp_rdata_o  out  128  load data; unused words zero
- wbm_cyc_o  out  1  equals wbm_stb_o
- wbm_stb_o  out  1  strobe
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  always 4'hF while stb is high, else 0
- wbm_adr_o  out  32  bus address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  acknowledge

Behaviour:
- Reset: all outputs 0 except cmd_ready_o=1. State=IDLE; internal counters and registers cleared. Asserting reset mid-sequence aborts immediately: stb/cyc drop asynchronously and no response is produced.
- Accept: a command is accepted on cmd_valid_i && cmd_ready_o; all cmd_* fields are registered at that edge.
- Store sequence:
  - write DATA_0..DATA_{n-1};
  - write ADDR = cmd_addr;
  - write CTRL = 32'h1.
- Load sequence:
  - write ADDR;
  - write CTRL = 32'h2;
  - read DATA_0..DATA_{n-1}, capturing wbm_dat_i into word k on the ack edge.
- States: IDLE -> XFER -> GAP -> (XFER | RESP) -> IDLE. A step index selects the address, we and data for each transfer.
- XFER:
  - stb/cyc/sel held and address/data stable until wbm_ack_i is sampled high.
  - Nominal timing: stb rises at t, ack is sampled at t+2, stb drops at t+3.
  - If the counter reaches TIMEOUT_CYCLES without ack: go to RESP with err=1 and rdata=0. The rest of the sequence is skipped.
- GAP:
  - stb low for exactly GAP_CYCLES; wbm_ack_i is ignored throughout.
  - Then the next XFER starts, or RESP if the sequence is done.
  - Nominal cost per transfer: 3+GAP_CYCLES = 5 cycles. A 4-word store takes 30 cycles from accept to rsp_valid.
- RESP: rsp_valid_o=1 for one cycle. rsp_rdata_o and rsp_err_o are held until the next accept. Returns to IDLE the next cycle.
- Back-to-back: cmd_ready_o is low during RESP, so the earliest next accept is the cycle after rsp_valid_o.
- Acks while stb is low: never counted.
- cmd_nwords_i: 0 is treated as 1; values above 4 are clamped to 4.
- Store data words at index >= n are not written to the bus.

Optional Feature:
- Macro: CFG_WB_LOADER_READBACK_EN.
- Defined: after the CTRL=1 write of a store, the block automatically runs the load sequence for the same address and nwords and compares the words read back.
  - Any mismatch sets rsp_err_o=1.
  - rsp_rdata_o returns the readback data.
  - Store latency grows by (2+n)*5 cycles.
- Undefined: store ends after the CTRL write, and rsp_rdata_o=0 for stores.

Decomposition:
- Shared package cfg_pkg holds:
  - register offsets ADDR_OFS=0x00, CTRL_OFS=0x04, DATA0_OFS=0x08 (stride 4);
  - CTRL codes CTRL_STORE=1, CTRL_LOAD=2;
  - state encoding.
- One natural sub-module, cfg_wb_xfer: a single-transfer engine that owns stb/ack/gap/timeout and exposes a req/done/err handshake. The parent cfg_wb_loader sequences the steps.

Test Plan:
- Store, conv1 bias: addr=0x030, n=4, wdata=0x00AB_..._1111 against a cfg model -> bus order DATA_0, DATA_1, DATA_2, DATA_3, ADDR, CTRL=1; rsp_valid_o at cycle 30; err=0.
- Load, fc bias: addr=0x300, n=1, model returns 0xDEADBEEF -> bus order ADDR, CTRL=2, read 0x30000008; rsp_rdata_o[31:0]=0xDEADBEEF, upper bits 0.
- Echo acks: slave holds ack 3 cycles per transfer -> gap acks are ignored, exactly 6 transfers are issued for a 4-word store, and no transfer is skipped.
- Timeout: slave never acks -> stb drops after 16 cycles; rsp_err_o=1; state returns to IDLE.
- Reset mid-XFER: rst_n_i low during step 2 -> stb, cyc and rsp_valid_o go to 0 immediately; cmd_ready_o=1 after release.
- READBACK_EN: model corrupts DATA_1 on read -> rsp_err_o=1; rsp_rdata_o returns the corrupted value.
